gameplay_frame_latch: RTL and testbench

- Consumer side of the gameplay output interface. Captures each gameplay result snapshot (ball position, speed, direction, camera angle, state) when `out_ready` pulses.
- Holds the latest snapshot in a shadow buffer and promotes it to a frame-stable front buffer only on `new_frame`, so the renderer never sees a mid-frame change.
- Tracks stale frames (no new snapshot since the last promotion) and overrun events (a snapshot was overwritten before it was displayed).

---
 rtl/gameplay_frame_latch.sv | 138 +++++++++++++
 tb/tb_gameplay_frame_latch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/gameplay_frame_latch.sv
// gameplay_frame_latch
//   Consumer side of the gameplay output interface. Each out_ready strobe
//   captures one gameplay snapshot into a shadow buffer. On new_frame, a
//   pending snapshot is promoted to a frame-stable front buffer. Because of
//   this, the renderer only ever sees a change at a frame boundary. The block
//   also tracks stale frames and lost (overwritten) snapshots.
//
// Ports
//   clk_in, rst_in (async, active high), clear_in (sync, same effect as reset)
//   out_ready        : strobe, the snapshot inputs are valid this cycle
//   ball_position_x/y, ball_speed, ball_direction, cam_angle [W], state_in [3]
//   new_frame        : strobe at the frame boundary
//   frame_*          : registered front-buffer copy of the snapshot
//   frame_valid      : front buffer has held a snapshot since reset/clear
//   frame_update     : one-cycle pulse after the front buffer was loaded
//   stale            : stale_frames >= STALE_LIMIT
//   stale_frames     : consecutive frames without promotion (saturating)
//   overrun_count    : snapshots overwritten before display (saturating)
module gameplay_frame_latch #(
   parameter int W           = 16,
   parameter int STALE_LIMIT = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             clear_in,
   input  logic             out_ready,
   input  logic [W-1:0]     ball_position_x,
   input  logic [W-1:0]     ball_position_y,
   input  logic [W-1:0]     ball_speed,
   input  logic [W-1:0]     ball_direction,
   input  logic [W-1:0]     cam_angle,
   input  logic [2:0]       state_in,
   input  logic             new_frame,
   output logic [W-1:0]     frame_ball_x,
   output logic [W-1:0]     frame_ball_y,
   output logic [W-1:0]     frame_speed,
   output logic [W-1:0]     frame_direction,
   output logic [W-1:0]     frame_cam_angle,
   output logic [2:0]       frame_state,
   output logic             frame_valid,
   output logic             frame_update,
   output logic             stale,
   output logic [CNT_W-1:0] stale_frames,
   output logic [CNT_W-1:0] overrun_count
);

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] speed;
      logic [W-1:0] dir;
      logic [W-1:0] cam;
      logic [2:0]   st;
   } snap_t;

   // The FSM state doubles as the "shadow pending" flag.
   typedef enum logic [1:0] {EMPTY, PENDING, SHOWN} fsm_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   fsm_t  state, state_nxt;
   snap_t shadow, front, sample;
   logic  promote, overrun;

   assign sample = '{x: ball_position_x, y: ball_position_y, speed: ball_speed,
                     dir: ball_direction, cam: cam_angle, st: state_in};

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      promote   = 1'b0;
      overrun   = 1'b0;
      if (clear_in) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY, SHOWN: begin
               // A sample arriving together with new_frame here is not shown
               // until the next frame boundary.
               if (out_ready) state_nxt = PENDING;
            end
            PENDING: begin
               if (new_frame) begin
                  promote = 1'b1;
                  if (!out_ready) state_nxt = SHOWN;
               end else if (out_ready) begin
                  overrun = 1'b1;  // undisplayed snapshot is overwritten
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         shadow        <= '0;
         front         <= '0;
         frame_valid   <= 1'b0;
         frame_update  <= 1'b0;
         stale_frames  <= '0;
         overrun_count <= '0;
      end else if (clear_in) begin
         shadow        <= '0;
         front         <= '0;
         frame_valid   <= 1'b0;
         frame_update  <= 1'b0;
         stale_frames  <= '0;
         overrun_count <= '0;
      end else begin
         if (out_ready) shadow <= sample;
         frame_update <= promote;
         if (promote) begin
            front        <= shadow;  // pre-edge shadow, not this cycle's sample
            frame_valid  <= 1'b1;
            stale_frames <= '0;
         end else if (new_frame && stale_frames != CNT_MAX) begin
            stale_frames <= stale_frames + 1'b1;
         end
         if (overrun && overrun_count != CNT_MAX)
            overrun_count <= overrun_count + 1'b1;
      end
   end

   assign stale           = (stale_frames >= CNT_W'(STALE_LIMIT));
   assign frame_ball_x    = front.x;
   assign frame_ball_y    = front.y;
   assign frame_speed     = front.speed;
   assign frame_direction = front.dir;
   assign frame_cam_angle = front.cam;
   assign frame_state     = front.st;

endmodule

// File: tb/tb_gameplay_frame_latch.sv
module tb_gameplay_frame_latch;

   localparam int W = 16;
   localparam int CNT_W = 8;

   logic clk_in = 1'b0, rst_in = 1'b1, clear_in = 1'b0;
   logic out_ready = 1'b0, new_frame = 1'b0;
   logic [W-1:0] ball_position_x = '0, ball_position_y = '0, ball_speed = '0;
   logic [W-1:0] ball_direction = '0, cam_angle = '0;
   logic [2:0]   state_in = '0;
   logic [W-1:0] frame_ball_x, frame_ball_y, frame_speed, frame_direction, frame_cam_angle;
   logic [2:0]   frame_state;
   logic         frame_valid, frame_update, stale;
   logic [CNT_W-1:0] stale_frames, overrun_count;

   int checks = 0;
   int failures = 0;

   gameplay_frame_latch #(.W(W), .STALE_LIMIT(4), .CNT_W(CNT_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .clear_in(clear_in), .out_ready(out_ready),
      .ball_position_x(ball_position_x), .ball_position_y(ball_position_y),
      .ball_speed(ball_speed), .ball_direction(ball_direction), .cam_angle(cam_angle),
      .state_in(state_in), .new_frame(new_frame),
      .frame_ball_x(frame_ball_x), .frame_ball_y(frame_ball_y), .frame_speed(frame_speed),
      .frame_direction(frame_direction), .frame_cam_angle(frame_cam_angle),
      .frame_state(frame_state), .frame_valid(frame_valid), .frame_update(frame_update),
      .stale(stale), .stale_frames(stale_frames), .overrun_count(overrun_count)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic ordy, input logic nf, input logic clr,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] cam, input logic [2:0] st);
      out_ready = ordy; new_frame = nf; clear_in = clr;
      ball_position_x = x; ball_position_y = y; cam_angle = cam; state_in = st;
      ball_speed = x + 16'd1; ball_direction = y + 16'd2;
      @(posedge clk_in); #1;
      out_ready = 1'b0; new_frame = 1'b0; clear_in = 1'b0;
   endtask

   task automatic idle();       step(0, 0, 0, 0, 0, 0, 0); endtask
   task automatic frame();      step(0, 1, 0, 0, 0, 0, 0); endtask
   task automatic cap(input logic [W-1:0] x); step(1, 0, 0, x, 0, 0, 0); endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_x"}, frame_ball_x, 0);
      chk({tag, "_y"}, frame_ball_y, 0);
      chk({tag, "_cam"}, frame_cam_angle, 0);
      chk({tag, "_st"}, frame_state, 0);
      chk({tag, "_valid"}, frame_valid, 0);
      chk({tag, "_upd"}, frame_update, 0);
      chk({tag, "_stale"}, stale, 0);
      chk({tag, "_sf"}, stale_frames, 0);
      chk({tag, "_ovr"}, overrun_count, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b0;
      chk_zero("reset");

      // Basic path
      step(1, 0, 0, 16'd100, 16'd200, 16'd45, 3'd3);
      idle();
      chk("basic_hold_x", frame_ball_x, 0);
      idle();
      frame();
      chk("basic_x", frame_ball_x, 100);
      chk("basic_y", frame_ball_y, 200);
      chk("basic_speed", frame_speed, 101);
      chk("basic_dir", frame_direction, 202);
      chk("basic_cam", frame_cam_angle, 45);
      chk("basic_st", frame_state, 3);
      chk("basic_upd", frame_update, 1);
      chk("basic_valid", frame_valid, 1);
      idle();
      chk("basic_upd_drop", frame_update, 0);
      chk("basic_valid_hold", frame_valid, 1);

      // Overrun
      cap(16'd10);
      cap(16'd20);
      chk("ovr_count", overrun_count, 1);
      frame();
      chk("ovr_x", frame_ball_x, 20);
      chk("ovr_count_after", overrun_count, 1);

      // Simultaneous capture + frame in PENDING
      cap(16'd5);
      step(1, 1, 0, 16'd6, 0, 0, 0);
      chk("sim_x", frame_ball_x, 5);
      chk("sim_upd", frame_update, 1);
      chk("sim_ovr", overrun_count, 1);
      frame();
      chk("sim_x2", frame_ball_x, 6);
      chk("sim_upd2", frame_update, 1);

      // Stale tracking
      repeat (3) frame();
      chk("stale3_sf", stale_frames, 3);
      chk("stale3", stale, 0);
      frame();
      chk("stale4_sf", stale_frames, 4);
      chk("stale4", stale, 1);
      chk("stale4_x", frame_ball_x, 6);
      chk("stale4_upd", frame_update, 0);
      step(1, 1, 0, 16'd77, 0, 0, 0);  // SHOWN: no promotion this frame
      chk("stale5_sf", stale_frames, 5);
      chk("stale5_x", frame_ball_x, 6);
      frame();
      chk("stale_clr_x", frame_ball_x, 77);
      chk("stale_clr_sf", stale_frames, 0);
      chk("stale_clr", stale, 0);
      repeat (300) frame();
      chk("stale_sat", stale_frames, 255);
      chk("stale_sat_flag", stale, 1);

      // Overrun saturation: 1 capture to PENDING, then 259 overruns
      repeat (260) cap(16'd9);
      chk("ovr_sat", overrun_count, 255);

      // Clear wins over out_ready + new_frame in PENDING
      step(1, 1, 1, 16'h55, 16'h66, 16'h77, 3'd5);
      chk_zero("clear");
      frame();  // EMPTY: no promotion, stale count advances
      chk("clear_nocap_x", frame_ball_x, 0);
      chk("clear_nocap_upd", frame_update, 0);
      chk("clear_nocap_sf", stale_frames, 1);

      // Asynchronous reset mid-operation
      cap(16'h1234);
      frame();
      chk("rst_pre_x", frame_ball_x, 16'h1234);
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      chk_zero("async_rst");
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      frame();
      chk("rst_empty_x", frame_ball_x, 0);
      chk("rst_empty_upd", frame_update, 0);
      chk("rst_empty_valid", frame_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
